// File: rtl/dbi_pkg.sv
// Shared DBI definitions: receiver FSM encoding and bus timing constants
// common to the DBI receiver and transmitter.
package dbi_pkg;

  typedef enum logic [1:0] {
    DBI_RX_IDLE      = 2'd0,
    DBI_RX_ACT_EMPTY = 2'd1,
    DBI_RX_ACT_HOLD  = 2'd2,
    DBI_RX_FLUSH     = 2'd3
  } dbi_rx_st_e;

  localparam real T_WRL_SEC      = 33e-9;
  localparam real T_WRH_SEC      = 33e-9;
  localparam real T_HRST_SEC     = 12e-6;
  localparam real T_HRST_MIN_SEC = 10e-6;

  // Truncating seconds-to-cycles conversion.
  function automatic int sec2cyc(input real sec, input int clk_hz);
    return $rtoi(sec * clk_hz);
  endfunction

endpackage

// File: rtl/dbi_sync.sv
// Multi-bit SYNC_STAGES flop synchronizer; every bit sees the same delay so a
// bus group stays aligned with its strobe.
module dbi_sync #(
  parameter int             W       = 1,
  parameter int             STAGES  = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [STAGES-1:0][W-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= {STAGES{RST_VAL}};
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/dbi_rx_phy.sv
// Write-only DBI receiver: synchronizes the bus, captures bytes on WRX rise,
// marks command/last via a one-byte hold stage and detects RESX hardware reset.
module dbi_rx_phy #(
  parameter int  INTERNAL_CLK   = 125000000,
  parameter int  DBI_IF_D_W     = 8,
  parameter real T_HRST_MIN_SEC = dbi_pkg::T_HRST_MIN_SEC,
  parameter int  SYNC_STAGES    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DBI_IF_D_W-1:0] dbi_d_i,
  input  logic                  dbi_csx_i,
  input  logic                  dbi_dcx_i,
  input  logic                  dbi_resx_i,
  input  logic                  dbi_rdx_i,
  input  logic                  dbi_wrx_i,
  output logic [DBI_IF_D_W-1:0] rx_dat_o,
  output logic                  rx_is_cmd_o,
  output logic                  rx_last_o,
  output logic                  rx_vld_o,
  input  logic                  rx_rdy_i,
  output logic                  rx_hrst_o,
  output logic                  rx_ovf_o,
  input  logic                  rx_ovf_clr_i
);
  import dbi_pkg::*;

  localparam int T_HRST_MIN_CYC = sec2cyc(T_HRST_MIN_SEC, INTERNAL_CLK);
  localparam int CNT_W          = (T_HRST_MIN_CYC > 2) ? $clog2(T_HRST_MIN_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(T_HRST_MIN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_PULSE = CNT_W'(T_HRST_MIN_CYC - 2);

  logic unused_rdx;
  assign unused_rdx = dbi_rdx_i;

  logic [DBI_IF_D_W-1:0] d_s;
  logic                  dcx_s, wrx_s, csx_s, resx_s;

  dbi_sync #(
    .W       (DBI_IF_D_W + 2),
    .STAGES  (SYNC_STAGES),
    .RST_VAL ({{DBI_IF_D_W{1'b0}}, 2'b11})
  ) u_sync_bus (
    .clk (clk),
    .rst (rst),
    .d   ({dbi_d_i, dbi_dcx_i, dbi_wrx_i}),
    .q   ({d_s, dcx_s, wrx_s})
  );

  dbi_sync #(
    .W       (2),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (2'b11)
  ) u_sync_ctl (
    .clk (clk),
    .rst (rst),
    .d   ({dbi_csx_i, dbi_resx_i}),
    .q   ({csx_s, resx_s})
  );

  // The synchronizer resets to CSX high, so the first SYNC_STAGES outputs after
  // reset are not real; csx_q stays low until then, so a CSX already low at
  // reset release is not mistaken for a falling edge.
  logic [SYNC_STAGES-1:0] primed;
  logic                   csx_q, wrx_q;
  logic                   csx_fall, capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      primed <= '0;
      csx_q  <= 1'b0;
      wrx_q  <= 1'b1;
    end else begin
      primed <= (primed << 1) | SYNC_STAGES'(1);
      csx_q  <= primed[SYNC_STAGES-1] ? csx_s : 1'b0;
      wrx_q  <= wrx_s;
    end
  end

  assign csx_fall = csx_q & ~csx_s;
  assign capture  = wrx_s & ~wrx_q & ~csx_s & resx_s;

  dbi_rx_st_e st, st_nxt;
  logic       push, push_last, hold_ld;
  logic [DBI_IF_D_W-1:0] hold_dat;
  logic                  hold_cmd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= DBI_RX_IDLE;
    else     st <= st_nxt;
  end

  // Capture is checked before CSX high, so a final byte always lands in hold
  // and leaves through FLUSH with last set.
  always_comb begin
    st_nxt    = st;
    push      = 1'b0;
    push_last = 1'b0;
    hold_ld   = 1'b0;
    case (st)
      DBI_RX_IDLE: begin
        if (csx_fall) st_nxt = DBI_RX_ACT_EMPTY;
      end
      DBI_RX_ACT_EMPTY: begin
        if (capture) begin
          hold_ld = 1'b1;
          st_nxt  = DBI_RX_ACT_HOLD;
        end else if (csx_s) begin
          st_nxt  = DBI_RX_IDLE;
        end
      end
      DBI_RX_ACT_HOLD: begin
        if (capture) begin
          hold_ld   = 1'b1;
          push      = 1'b1;
          push_last = ~dcx_s;
        end else if (csx_s) begin
          st_nxt    = DBI_RX_FLUSH;
        end
      end
      DBI_RX_FLUSH: begin
        push      = 1'b1;
        push_last = 1'b1;
        st_nxt    = DBI_RX_IDLE;
      end
      default: st_nxt = DBI_RX_IDLE;
    endcase
    if (rx_hrst_o) begin
      st_nxt  = DBI_RX_IDLE;
      push    = 1'b0;
      hold_ld = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_dat <= '0;
      hold_cmd <= 1'b0;
    end else if (rx_hrst_o) begin
      hold_dat <= '0;
      hold_cmd <= 1'b0;
    end else if (hold_ld) begin
      hold_dat <= d_s;
      hold_cmd <= ~dcx_s;
    end
  end

  // A push into a full, stalled output register is dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_dat_o    <= '0;
      rx_is_cmd_o <= 1'b0;
      rx_last_o   <= 1'b0;
      rx_vld_o    <= 1'b0;
    end else if (rx_hrst_o) begin
      rx_dat_o    <= '0;
      rx_is_cmd_o <= 1'b0;
      rx_last_o   <= 1'b0;
      rx_vld_o    <= 1'b0;
    end else if (push && (!rx_vld_o || rx_rdy_i)) begin
      rx_dat_o    <= hold_dat;
      rx_is_cmd_o <= hold_cmd;
      rx_last_o   <= push_last;
      rx_vld_o    <= 1'b1;
    end else if (rx_vld_o && rx_rdy_i) begin
      rx_vld_o    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 rx_ovf_o <= 1'b0;
    else if (push && rx_vld_o && !rx_rdy_i)  rx_ovf_o <= 1'b1;
    else if (rx_ovf_clr_i)                   rx_ovf_o <= 1'b0;
  end

  // Counter saturates one past the pulse value, so each low period pulses once.
  logic [CNT_W-1:0] hrst_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hrst_cnt  <= '0;
      rx_hrst_o <= 1'b0;
    end else begin
      rx_hrst_o <= !resx_s && (hrst_cnt == CNT_PULSE);
      if (resx_s)                   hrst_cnt <= '0;
      else if (hrst_cnt != CNT_MAX) hrst_cnt <= hrst_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dbi_rx_phy.sv
// Directed bench for dbi_rx_phy: DBI write sequences with hand-computed beats,
// back-pressure/overflow, RESX hardware reset and mid-transaction rst.
module tb_dbi_rx_phy;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] dbi_d_i = '0;
  logic       dbi_csx_i = 1'b1, dbi_dcx_i = 1'b1, dbi_resx_i = 1'b1;
  logic       dbi_rdx_i = 1'b1, dbi_wrx_i = 1'b1;
  logic [7:0] rx_dat_o;
  logic       rx_is_cmd_o, rx_last_o, rx_vld_o, rx_hrst_o, rx_ovf_o;
  logic       rx_rdy_i = 1'b1, rx_ovf_clr_i = 1'b0;

  dbi_rx_phy dut (
    .clk          (clk),
    .rst          (rst),
    .dbi_d_i      (dbi_d_i),
    .dbi_csx_i    (dbi_csx_i),
    .dbi_dcx_i    (dbi_dcx_i),
    .dbi_resx_i   (dbi_resx_i),
    .dbi_rdx_i    (dbi_rdx_i),
    .dbi_wrx_i    (dbi_wrx_i),
    .rx_dat_o     (rx_dat_o),
    .rx_is_cmd_o  (rx_is_cmd_o),
    .rx_last_o    (rx_last_o),
    .rx_vld_o     (rx_vld_o),
    .rx_rdy_i     (rx_rdy_i),
    .rx_hrst_o    (rx_hrst_o),
    .rx_ovf_o     (rx_ovf_o),
    .rx_ovf_clr_i (rx_ovf_clr_i)
  );

  always #4 clk = ~clk;

  int         cyc = 0;
  int         hrst_cnt = 0;
  int         hrst_cyc = 0;
  logic [9:0] beats[$];
  int         rd_idx = 0;
  int         n_tests = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Beat monitor: {dat, is_cmd, last} recorded on every handshake.
  always @(negedge clk) begin
    if (rx_vld_o && rx_rdy_i) beats.push_back({rx_dat_o, rx_is_cmd_o, rx_last_o});
    if (rx_hrst_o) begin
      hrst_cnt++;
      hrst_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic is_cmd, input logic [7:0] v);
    dbi_dcx_i = ~is_cmd;
    dbi_d_i   = v;
    dbi_wrx_i = 1'b0;
    tick(4);
    dbi_wrx_i = 1'b1;
    tick(4);
  endtask

  task automatic cs_lo();
    dbi_csx_i = 1'b0;
    tick(4);
  endtask

  task automatic cs_hi();
    dbi_csx_i = 1'b1;
    tick(8);
  endtask

  task automatic expect_beat(input string tag, input logic [7:0] d, input logic c, input logic l);
    chk({tag, "_avail"}, 32'(beats.size() > rd_idx), 32'd1);
    if (beats.size() > rd_idx) begin
      chk(tag, 32'(beats[rd_idx]), 32'({d, c, l}));
      rd_idx++;
    end
  endtask

  initial begin
    tick(3);
    chk("rst_vld",  32'(rx_vld_o),    0);
    chk("rst_dat",  32'(rx_dat_o),    0);
    chk("rst_cmd",  32'(rx_is_cmd_o), 0);
    chk("rst_last", 32'(rx_last_o),   0);
    chk("rst_hrst", 32'(rx_hrst_o),   0);
    chk("rst_ovf",  32'(rx_ovf_o),    0);
    rst = 1'b0;
    tick(6);

    // Long command
    cs_lo();
    wr_byte(1, 8'h2A); wr_byte(0, 8'h00); wr_byte(0, 8'h00);
    wr_byte(0, 8'h00); wr_byte(0, 8'hEF);
    cs_hi();
    chk("long_n", 32'(beats.size() - rd_idx), 5);
    expect_beat("long0", 8'h2A, 1, 0);
    expect_beat("long1", 8'h00, 0, 0);
    expect_beat("long2", 8'h00, 0, 0);
    expect_beat("long3", 8'h00, 0, 0);
    expect_beat("long4", 8'hEF, 0, 1);

    // Single command
    cs_lo();
    wr_byte(1, 8'h29);
    cs_hi();
    chk("single_n", 32'(beats.size() - rd_idx), 1);
    expect_beat("single", 8'h29, 1, 1);

    // Back-to-back commands in one CSX low
    cs_lo();
    wr_byte(1, 8'h2A); wr_byte(0, 8'h00); wr_byte(0, 8'h10);
    wr_byte(1, 8'h2C); wr_byte(0, 8'hFF);
    cs_hi();
    chk("b2b_n", 32'(beats.size() - rd_idx), 5);
    expect_beat("b2b0", 8'h2A, 1, 0);
    expect_beat("b2b1", 8'h00, 0, 0);
    expect_beat("b2b2", 8'h10, 0, 1);
    expect_beat("b2b3", 8'h2C, 1, 0);
    expect_beat("b2b4", 8'hFF, 0, 1);

    // Back-pressure and overflow
    rx_rdy_i = 1'b0;
    cs_lo();
    wr_byte(1, 8'h3A); wr_byte(0, 8'h11);
    chk("bp_ovf0", 32'(rx_ovf_o), 0);
    wr_byte(0, 8'h22);
    chk("bp_dat1", 32'(rx_dat_o), 32'h3A);
    chk("bp_ovf1", 32'(rx_ovf_o), 1);
    wr_byte(0, 8'h33);
    chk("bp_dat2", 32'(rx_dat_o), 32'h3A);
    chk("bp_cmd2", 32'(rx_is_cmd_o), 1);
    chk("bp_last2", 32'(rx_last_o), 0);
    chk("bp_vld2", 32'(rx_vld_o), 1);
    rx_rdy_i = 1'b1;
    tick(3);
    cs_hi();
    chk("bp_n", 32'(beats.size() - rd_idx), 2);
    expect_beat("bp0", 8'h3A, 1, 0);
    expect_beat("bp1", 8'h33, 0, 1);
    chk("bp_ovf_sticky", 32'(rx_ovf_o), 1);
    rx_ovf_clr_i = 1'b1;
    tick(1);
    rx_ovf_clr_i = 1'b0;
    chk("bp_ovf_clr", 32'(rx_ovf_o), 0);

    // Hardware reset: 12 us low pulses once, 1249 cycles after the synced fall
    begin
      int t0;
      t0 = cyc;
      dbi_resx_i = 1'b0;
      tick(1500);
      dbi_resx_i = 1'b1;
      tick(10);
      chk("hrst_cnt", 32'(hrst_cnt), 1);
      chk("hrst_dly", 32'(hrst_cyc - t0), 32'(2 + 1249));
    end
    dbi_resx_i = 1'b0;
    tick(625);
    dbi_resx_i = 1'b1;
    tick(10);
    chk("hrst_short", 32'(hrst_cnt), 1);

    // Hardware reset mid-transaction drops pending beats
    rx_rdy_i = 1'b0;
    cs_lo();
    wr_byte(1, 8'h2A); wr_byte(0, 8'h00); wr_byte(0, 8'h00);
    chk("hmid_vld0", 32'(rx_vld_o), 1);
    dbi_resx_i = 1'b0;
    tick(1500);
    dbi_resx_i = 1'b1;
    tick(10);
    chk("hmid_cnt", 32'(hrst_cnt), 2);
    chk("hmid_vld", 32'(rx_vld_o), 0);
    chk("hmid_dat", 32'(rx_dat_o), 0);
    rx_rdy_i = 1'b1;
    tick(2);
    cs_hi();
    chk("hmid_n", 32'(beats.size() - rd_idx), 0);

    // rst mid-transaction with CSX held low
    rx_rdy_i = 1'b0;
    cs_lo();
    wr_byte(1, 8'h2A); wr_byte(0, 8'h00); wr_byte(0, 8'h00);
    rst = 1'b1;
    tick(2);
    chk("mrst_vld",  32'(rx_vld_o),    0);
    chk("mrst_dat",  32'(rx_dat_o),    0);
    chk("mrst_cmd",  32'(rx_is_cmd_o), 0);
    chk("mrst_ovf",  32'(rx_ovf_o),    0);
    rst = 1'b0;
    tick(6);
    rx_rdy_i = 1'b1;
    wr_byte(0, 8'h55); wr_byte(0, 8'h66);
    cs_hi();
    chk("mrst_n", 32'(beats.size() - rd_idx), 0);

    // Fresh transaction after recovery
    cs_lo();
    wr_byte(1, 8'h29);
    cs_hi();
    chk("post_n", 32'(beats.size() - rd_idx), 1);
    expect_beat("post", 8'h29, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
